// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional 2-entry skid buffer, flush,
// occupancy reporting and saturating stall/flush performance counters.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | no valid entry, out_valid=0
// ST_ONE   | main entry valid, skid entry free
// ST_FULL  | main and skid entries valid, upstream held off
module pipe_stage_skid #(
  parameter int                DATA_W   = 19,
  parameter bit                SKID_EN  = 1'b1,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_ready_q;
  logic              acc_in, acc_out;
  logic              ld_main_in, ld_main_skid, ld_skid;
  logic              stall_ev, flush_ev;

  // With SKID_EN=0 the FULL state is unreachable: in_ready is low whenever
  // ONE is held without a downstream transfer.
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid || out_ready);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = state_q;
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;
  assign stall_ev  = out_valid && !out_ready;
  assign flush_ev  = flush && (state_q != ST_EMPTY);

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc_in) begin
          state_d    = ST_ONE;
          ld_main_in = 1'b1;
        end
        ST_ONE: begin
          if (acc_in && acc_out) begin
            ld_main_in = 1'b1;
          end else if (acc_in) begin
            state_d = ST_FULL;
            ld_skid = 1'b1;
          end else if (acc_out) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (acc_out) begin
          state_d      = ST_ONE;
          ld_main_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= RST_DATA;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (flush)
        main_q <= RST_DATA;
      else if (ld_main_in)
        main_q <= in_data;
      else if (ld_main_skid)
        main_q <= skid_q;
      if (ld_skid)
        skid_q <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_ev && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a skid instance (A) and a
// single-register instance with 2-bit counters (B).
module tb_pipe_stage_skid;

  localparam int               DW    = 19;
  localparam logic [DW-1:0]    RST_A = 19'h2A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic          a_flush, a_cnt_clr;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic [15:0]   a_stall_cnt, a_flush_cnt;

  logic          b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic          b_flush, b_cnt_clr;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
  logic [1:0]    b_stall_cnt, b_flush_cnt;

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(16), .RST_DATA(RST_A)) u_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .flush(a_flush), .cnt_clr(a_cnt_clr), .occ(a_occ),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(2), .RST_DATA('0)) u_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .flush(b_flush), .cnt_clr(b_cnt_clr), .occ(b_occ),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] nxt_in, nxt_out;
  logic          mv, exp_rdy;
  logic [1:0]    sat_exp [6];

  initial begin
    a_rst = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    a_flush = 1'b0; a_cnt_clr = 1'b0;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    b_flush = 1'b0; b_cnt_clr = 1'b0;
    tick;
    tick;
    check_val("rst_out_valid", a_out_valid, 0);
    check_val("rst_out_data",  a_out_data, RST_A);
    check_val("rst_occ",       a_occ, 0);
    check_val("rst_in_ready",  a_in_ready, 1);
    check_val("rst_stall",     a_stall_cnt, 0);
    check_val("rst_flush",     a_flush_cnt, 0);
    check_val("rst_b_in_ready", b_in_ready, 1);
    a_rst = 1'b1;
    b_rst = 1'b1;

    // stream 1,2,3 at full throughput
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in_data = DW'(i);
      tick;
      check_val("stream_valid", a_out_valid, 1);
      check_val("stream_data",  a_out_data, i);
      check_val("stream_occ",   a_occ, 1);
      check_val("stream_rdy",   a_in_ready, 1);
    end
    a_in_valid = 1'b0; a_in_data = 'x;
    tick;
    check_val("stream_drain", a_out_valid, 0);
    check_val("stream_stall", a_stall_cnt, 0);
    check_val("stream_noX",   a_out_data, 3);

    // skid fill and ordered drain
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 19'h0AA;
    tick;
    check_val("fill1_occ",  a_occ, 1);
    check_val("fill1_rdy",  a_in_ready, 1);
    a_in_data = 19'h0BB;
    tick;
    check_val("fill2_occ",  a_occ, 2);
    check_val("fill2_rdy",  a_in_ready, 0);
    check_val("fill2_data", a_out_data, 19'h0AA);
    a_in_data = 19'h0CC;
    tick;
    tick;
    check_val("hold_occ",   a_occ, 2);
    check_val("hold_data",  a_out_data, 19'h0AA);
    check_val("hold_stall", a_stall_cnt, 3);
    a_out_ready = 1'b1;
    tick;
    check_val("drain1_data", a_out_data, 19'h0BB);
    check_val("drain1_occ",  a_occ, 1);
    check_val("drain1_rdy",  a_in_ready, 1);
    tick;
    check_val("drain2_data", a_out_data, 19'h0CC);
    check_val("drain2_occ",  a_occ, 1);
    a_in_valid = 1'b0;
    tick;
    check_val("drain3_valid", a_out_valid, 0);
    check_val("drain_stall",  a_stall_cnt, 3);

    // flush while FULL with a same-cycle push
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 19'h011;
    tick;
    a_in_data = 19'h022;
    tick;
    check_val("pre_flush_occ", a_occ, 2);
    a_flush = 1'b1; a_in_data = 19'h1FF;
    tick;
    check_val("flush_valid", a_out_valid, 0);
    check_val("flush_occ",   a_occ, 0);
    check_val("flush_data",  a_out_data, RST_A);
    check_val("flush_rdy",   a_in_ready, 1);
    check_val("flush_cnt",   a_flush_cnt, 1);
    check_val("flush_stall", a_stall_cnt, 5);
    a_flush = 1'b0; a_in_valid = 1'b0;
    tick;
    check_val("flush_no1ff", a_out_valid, 0);
    a_flush = 1'b1;
    tick;
    check_val("flush_empty_cnt", a_flush_cnt, 1);
    a_flush = 1'b0;

    // reset mid-operation in FULL, together with flush
    a_in_valid = 1'b1; a_in_data = 19'h033;
    tick;
    a_in_data = 19'h044;
    tick;
    check_val("pre_rst_occ", a_occ, 2);
    a_rst = 1'b0; a_flush = 1'b1; a_in_data = 19'h077;
    tick;
    check_val("mrst_valid", a_out_valid, 0);
    check_val("mrst_data",  a_out_data, RST_A);
    check_val("mrst_occ",   a_occ, 0);
    check_val("mrst_rdy",   a_in_ready, 1);
    check_val("mrst_stall", a_stall_cnt, 0);
    check_val("mrst_flush", a_flush_cnt, 0);
    a_rst = 1'b1; a_flush = 1'b0; a_in_data = 19'h055; a_out_ready = 1'b1;
    tick;
    check_val("post_rst_valid", a_out_valid, 1);
    check_val("post_rst_data",  a_out_data, 19'h055);
    a_in_valid = 1'b0;

    // SKID_EN=0: out_ready toggling under continuous in_valid
    nxt_in = 19'h010; nxt_out = 19'h010; mv = 1'b0;
    b_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      b_out_ready = (c % 2 == 0);
      b_in_data = nxt_in;
      #1;
      exp_rdy = !mv || b_out_ready;
      check_val("b_in_ready",  b_in_ready, exp_rdy);
      check_val("b_out_valid", b_out_valid, mv);
      check_val("b_occ",       b_occ, {1'b0, mv});
      if (mv && b_out_ready) begin
        check_val("b_order", b_out_data, nxt_out);
        nxt_out++;
      end
      if (exp_rdy) begin
        mv = 1'b1;
        nxt_in++;
      end else if (mv && b_out_ready) begin
        mv = 1'b0;
      end
      tick;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1;
    if (mv) begin
      check_val("b_order_last", b_out_data, nxt_out);
      nxt_out++;
    end
    tick;
    check_val("b_drained", b_out_valid, 0);
    check_val("b_all_out", nxt_out, 19'h015);

    // 2-bit stall counter saturation and clear-over-increment
    b_in_valid = 1'b1; b_in_data = 19'h099; b_out_ready = 1'b0; b_cnt_clr = 1'b1;
    tick;
    b_in_valid = 1'b0; b_cnt_clr = 1'b0;
    check_val("sat_start", b_stall_cnt, 0);
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 6; k++) begin
      tick;
      check_val("sat_stall", b_stall_cnt, sat_exp[k]);
    end
    check_val("sat_hold_data", b_out_data, 19'h099);
    b_cnt_clr = 1'b1;
    tick;
    check_val("clr_stall", b_stall_cnt, 0);
    b_cnt_clr = 1'b0; b_flush = 1'b1;
    tick;
    check_val("b_flush_cnt",   b_flush_cnt, 1);
    check_val("b_flush_stall", b_stall_cnt, 1);
    check_val("b_flush_valid", b_out_valid, 0);
    check_val("b_flush_rdy",   b_in_ready, 1);
    b_flush = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/REG).
- One instance carries an arbitrary payload (control bits, operands, PC, instruction) between two pipeline stages.
- Uses a valid/ready handshake, so stalls back-pressure upstream instead of being hand-wired per stage.
- Adds flush, an optional 2-entry skid buffer (registered in_ready, full throughput), occupancy reporting and saturating stall/flush performance counters.

Parameters:
- DATA_W, 19: payload width in bits (>=1).
- SKID_EN, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of the performance counters (>=2).
- RST_DATA, 0: value loaded into out_data on reset and on flush (DATA_W bits).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream presents a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready.
- out_valid  out  1  payload available downstream.
- out_data  out  DATA_W  downstream payload, i.e. the main entry.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- flush  in  1  discard all held entries and the same-cycle input.
- cnt_clr  in  1  synchronous clear of both counters.
- occ  out  2  number of valid entries (0..2; 0..1 when SKID_EN=0).
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
- flush_cnt  out  CNT_W  flush cycles that dropped at least one valid entry.

Behaviour:
- Reset (rst==0 at a rising edge):
  - out_valid=0, out_data=RST_DATA, occ=0, stall_cnt=0, flush_cnt=0.
  - Skid entry invalid.
  - in_ready=1 from the first cycle after reset (SKID_EN=1). With SKID_EN=0, in_ready follows its combinational equation, which gives 1.
  - Reset overrides flush, cnt_clr and any transfer in the same cycle.
  - Reset mid-transfer drops all held data.
- Priority per edge: reset > flush > normal transfers. Counters update in parallel with these, subject to reset.
- SKID_EN=1 state machine, where acc_in = in_valid&&in_ready and acc_out = out_valid&&out_ready:
  - EMPTY (occ=0): acc_in -> ONE, main<=in_data.
  - ONE (occ=1):
    - acc_in & acc_out -> ONE, main<=in_data.
    - acc_in & !acc_out -> FULL, skid<=in_data.
    - !acc_in & acc_out -> EMPTY.
    - otherwise hold.
  - FULL (occ=2): acc_out -> ONE, main<=skid; otherwise hold.
  - in_ready = (state != FULL), driven from a flop with no combinational path from out_ready.
  - Latency 1 cycle from acc_in to out_valid when the stage was EMPTY.
  - Throughput 1 transfer per cycle when out_ready is held high.
  - Ordering is strictly FIFO: the main entry always leaves before the skid entry.
- SKID_EN=0:
  - Single entry. in_ready = !out_valid || out_ready (combinational).
  - acc_in loads main and sets out_valid. acc_out without acc_in clears out_valid.
  - Simultaneous acc_in and acc_out keeps out_valid=1 with the new data.
- Payload stability: out_data and out_valid hold unchanged while out_valid && !out_ready (no retraction, no change), except on flush or reset.
- Flush:
  - Next state is EMPTY: out_valid=0, occ=0, out_data=RST_DATA.
  - The same-cycle in_data is discarded even if in_valid && in_ready.
  - Any same-cycle acc_out is still considered delivered downstream.
  - in_ready=1 on the following cycle.
  - Flush while EMPTY is a no-op apart from out_data=RST_DATA.
- occ equals the state encoding. It is registered and updates in the same edge as the data.
- Counters:
  - Both saturate at 2^CNT_W-1; no wrap-around.
  - stall_cnt increments on each edge where out_valid && !out_ready, including the flush cycle.
  - flush_cnt increments on flush && occ!=0.
  - cnt_clr zeroes both counters. If cnt_clr coincides with an increment event, the result is 0.
- Undefined input (X) on in_data while in_valid=0 must not propagate to out_data.

Test Plan:
- Reset then stream: rst=0 for 2 cycles; then in_valid=1 with in_data=0x00001,0x00002,0x00003 on consecutive cycles, out_ready=1 -> out_data 1,2,3 on cycles 1,2,3 after the first transfer; occ stays 1; in_ready never drops; stall_cnt=0.
- Skid fill (SKID_EN=1): out_ready=0; push 0x0AA then 0x0BB -> occ=2, in_ready=0 next cycle, 0x0CC held off upstream. Then out_ready=1 -> outputs 0x0AA, 0x0BB, 0x0CC in order with no loss or duplication; stall_cnt counts the exact number of blocked cycles.
- Flush while FULL with a same-cycle in_valid (0x1FF) -> next cycle out_valid=0, occ=0, out_data=RST_DATA, in_ready=1, flush_cnt=1. 0x1FF never appears on the output. A flush while EMPTY leaves flush_cnt unchanged.
- SKID_EN=0 instance: out_ready toggling 1,0,1,0 under continuous in_valid -> in_ready equals !out_valid||out_ready each cycle; every accepted word appears exactly once, in order.
- Counter saturation with CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3. Then cnt_clr=1 together with a stall -> stall_cnt=0.
- Reset mid-operation: in FULL state assert rst=0 for one edge together with flush=1 and cnt_clr=0 -> all outputs at reset values, counters 0; the next push of 0x055 appears after 1 cycle.
